// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - data-memory request/ready handshake
interface pipeline_hazard_ctrl_if;

  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);

endinterface

// File: rtl/mem_wait_fsm.sv
// rtl/mem_wait_fsm.sv - data-memory request FSM with wait-timeout trap
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic mem_ready,
  output logic mem_req,
  output logic mem_stall,
  output logic mem_err
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    mem_req       = 1'b0;
    mem_stall     = 1'b0;
    mem_err       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          mem_req = mem_op;
          if (mem_op && !mem_ready) begin
            mem_stall     = 1'b1;
            state_next    = WAIT;
            // the unready IDLE cycle is the first one toward the timeout
            wait_cnt_next = 8'd1;
          end
        end
        WAIT: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            state_next    = IDLE;
            wait_cnt_next = 8'd0;
          end else begin
            mem_stall = 1'b1;
            if (wait_cnt == LAST) state_next = TRAP;
            else                  wait_cnt_next = wait_cnt + 8'd1;
          end
        end
        TRAP: begin
          mem_stall = 1'b1;
          mem_err   = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the five-stage pipeline
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            RdE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  pipeline_hazard_ctrl_if.master mem,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  mem_err,
  output logic [DATA_WIDTH-1:0] stall_cnt
);

  logic req;
  logic mem_stall;
  logic lw_stall;

  mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .mem_op    (MemReadM | MemWriteM),
    .mem_ready (mem.mem_ready),
    .mem_req   (req),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  assign mem.mem_req = req;
  assign mem.mem_we  = req & MemWriteM;

  assign lw_stall = (ResultSrcE == RESULT_MEM) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      // freeze everything; D/E flushes wait until the memory releases
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = PCSrcE | lw_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (StallF && (stall_cnt != '1))
      stall_cnt <= stall_cnt + DATA_WIDTH'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemReadM, MemWriteM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW, mem_err;
  logic [3:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl_if mif ();

  pipeline_hazard_ctrl #(.DATA_WIDTH(4), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .mem        (mif.master),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err}
  function automatic logic [9:0] outs();
    return {mif.mem_req, mif.mem_we, StallF, StallD, StallE, StallM,
            FlushD, FlushE, FlushW, mem_err};
  endfunction

  task automatic set_in(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [1:0] rsrc, input logic pc,
                        input logic mr, input logic mw, input logic rdy);
    @(negedge clk);
    rst = r; Rs1D = rs1; Rs2D = rs2; RdE = rd; ResultSrcE = rsrc;
    PCSrcE = pc; MemReadM = mr; MemWriteM = mw; mif.mem_ready = rdy;
    #2;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    vectors++;
    if (outs() !== 10'b0000001110) begin
      miscompares++; $display("FAIL reset_outs: got %b want %b", outs(), 10'b0000001110);
    end
    set_in(1, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    vectors++;
    if (stall_cnt !== 4'd0 || mem_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_state: cnt %h err %b want 0 0", stall_cnt, mem_err);
    end
    set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000000000) begin
      miscompares++; $display("FAIL reset_release: got %b want %b", outs(), 10'b0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(0, 5, 0, 5, 2'b01, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0011000100) begin
      miscompares++; $display("FAIL load_use_rs1: got %b want %b", outs(), 10'b0011000100);
    end
    set_in(0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000000000) begin
      miscompares++; $display("FAIL load_use_rd0: got %b want %b", outs(), 10'b0);
    end
    vectors++;
    if (stall_cnt !== 4'd1) begin
      miscompares++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    end
    set_in(0, 1, 7, 7, 2'b01, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0011000100) begin
      miscompares++; $display("FAIL load_use_rs2: got %b want %b", outs(), 10'b0011000100);
    end
    set_in(0, 7, 0, 7, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000000000) begin
      miscompares++; $display("FAIL load_use_alu: got %b want %b", outs(), 10'b0);
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000001100) begin
      miscompares++; $display("FAIL branch: got %b want %b", outs(), 10'b0000001100);
    end
    set_in(0, 3, 0, 3, 2'b01, 1, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0011001100) begin
      miscompares++; $display("FAIL branch_lw: got %b want %b", outs(), 10'b0011001100);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
      vectors++;
      if (outs() !== 10'b1011110010) begin
        miscompares++; $display("FAIL mem_wait_c%0d: got %b want %b", i, outs(), 10'b1011110010);
      end
    end
    set_in(0, 0, 0, 0, 2'b00, 1, 1, 0, 1);
    vectors++;
    if (outs() !== 10'b1000001100) begin
      miscompares++; $display("FAIL mem_wait_release: got %b want %b", outs(), 10'b1000001100);
    end
    set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000000000 || stall_cnt !== 4'd3) begin
      miscompares++; $display("FAIL mem_wait_after: got %b cnt %0d want %b cnt 3", outs(), stall_cnt, 10'b0);
    end
  endtask

  task automatic test_zero_wait_store();
    do_reset();
    set_in(0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
    vectors++;
    if (outs() !== 10'b1100000000) begin
      miscompares++; $display("FAIL store_zero_wait: got %b want %b", outs(), 10'b1100000000);
    end
    set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000000000 || stall_cnt !== 4'd0) begin
      miscompares++; $display("FAIL store_after: got %b cnt %0d want %b cnt 0", outs(), stall_cnt, 10'b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
      vectors++;
      if (outs() !== 10'b1011110010) begin
        miscompares++; $display("FAIL timeout_wait_c%0d: got %b want %b", i, outs(), 10'b1011110010);
      end
    end
    set_in(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    vectors++;
    if (outs() !== 10'b0011110011) begin
      miscompares++; $display("FAIL timeout_trap: got %b want %b", outs(), 10'b0011110011);
    end
    set_in(0, 0, 0, 0, 2'b00, 1, 0, 0, 1);
    vectors++;
    if (outs() !== 10'b0011110011 || stall_cnt !== 4'd5) begin
      miscompares++; $display("FAIL timeout_sticky: got %b cnt %0d want %b cnt 5", outs(), stall_cnt, 10'b0011110011);
    end
    set_in(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000001110) begin
      miscompares++; $display("FAIL timeout_rst: got %b want %b", outs(), 10'b0000001110);
    end
    set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000000000 || stall_cnt !== 4'd0) begin
      miscompares++; $display("FAIL timeout_cleared: got %b cnt %0d want %b cnt 0", outs(), stall_cnt, 10'b0);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    set_in(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    set_in(1, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    vectors++;
    if (outs() !== 10'b0000001110) begin
      miscompares++; $display("FAIL rst_in_wait: got %b want %b", outs(), 10'b0000001110);
    end
    set_in(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vectors++;
    if (outs() !== 10'b0000000000) begin
      miscompares++; $display("FAIL rst_in_wait_idle: got %b want %b", outs(), 10'b0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
      if (i == 14 || i == 15 || i == 19) begin
        vectors++;
        if (stall_cnt !== ((i < 15) ? 4'(i) : 4'hF)) begin
          miscompares++; $display("FAIL saturate_i%0d: got %h want %h", i, stall_cnt, ((i < 15) ? 4'(i) : 4'hF));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0; ResultSrcE = '0;
    PCSrcE = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; mif.mem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_zero_wait_store();
    test_timeout();
    test_reset_in_wait();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
